// File: rtl/sdmf_reduce_arbiter.sv
// Round-robin arbiter funnelling NUM_SRC SDMF triple streams into one reduce engine port.
// Define SDMF_ARB_STATS_EN to add per-source completed-frame counters on frame_cnt.
module sdmf_reduce_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DW      = 24,
   parameter int IDW     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     s_frame_valid,
   input  logic [2*NUM_SRC-1:0]   s_EFF,
   input  logic [NUM_SRC-1:0]     s_tvalid,
   input  logic [NUM_SRC-1:0]     s_tlast,
   output logic [NUM_SRC-1:0]     s_tready,
   input  logic [NUM_SRC*DW-1:0]  s_tdata,
   output logic [NUM_SRC-1:0]     s_EF_ack,
   output logic                   m_frame_valid,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   input  logic                   m_tready,
   output logic [1:0]             m_EFF,
   output logic [DW-1:0]          m_tdata,
   input  logic                   m_EF_ack,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy
`ifdef SDMF_ARB_STATS_EN
   ,
   output logic [NUM_SRC*16-1:0]  frame_cnt
`endif
);

   // state  | meaning
   // S_IDLE | no owner; pick next requester after last_grant
   // S_XFER | data frame of grant_id passes straight through
   // S_EMPTY| empty frame of grant_id; wait for engine acknowledge
   typedef enum logic [1:0] {S_IDLE, S_XFER, S_EMPTY} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   win;
   logic             found;
   int               g;

   assign g        = int'(grant_q);
   assign grant_id = grant_q;
   assign busy     = (state_q != S_IDLE);

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (!found && s_frame_valid[(int'(last_q) + k) % NUM_SRC]) begin
            found = 1'b1;
            win   = IDW'((int'(last_q) + k) % NUM_SRC);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      m_frame_valid = 1'b0;
      m_tvalid      = 1'b0;
      m_tlast       = 1'b0;
      m_tdata       = '0;
      m_EFF         = 2'b00;
      s_tready      = '0;
      s_EF_ack      = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = win;
               state_d = (s_EFF[int'(win)*2 +: 2] != 2'b00) ? S_EMPTY : S_XFER;
            end
         end
         S_XFER: begin
            m_frame_valid = 1'b1;
            m_tvalid      = s_tvalid[g];
            m_tlast       = s_tlast[g];
            m_tdata       = s_tdata[g*DW +: DW];
            s_tready[g]   = m_tready;
            if (s_tvalid[g] && m_tready && s_tlast[g]) begin
               state_d = S_IDLE;
               last_d  = grant_q;
            end
         end
         S_EMPTY: begin
            m_frame_valid = 1'b1;
            m_EFF         = s_EFF[g*2 +: 2];
            s_EF_ack[g]   = m_EF_ack;
            if (m_EF_ack) begin
               state_d = S_IDLE;
               last_d  = grant_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NUM_SRC - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef SDMF_ARB_STATS_EN
   logic [NUM_SRC*16-1:0] frame_cnt_q, frame_cnt_d;
   logic                  done;

   assign done = ((state_q == S_XFER) && s_tvalid[g] && m_tready && s_tlast[g]) ||
                 ((state_q == S_EMPTY) && m_EF_ack);

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (done)
         frame_cnt_d[g*16 +: 16] = frame_cnt_q[g*16 +: 16] + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_cnt_q <= '0;
      else       frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sdmf_reduce_arbiter.sv
// Directed bench for sdmf_reduce_arbiter: ordering, empty frames, backpressure, mid-frame reset.
module tb_sdmf_reduce_arbiter;
   localparam int NS = 4;
   localparam int DW = 24;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NS-1:0]     s_frame_valid = '0;
   logic [2*NS-1:0]   s_EFF = '0;
   logic [NS-1:0]     s_tvalid = '0;
   logic [NS-1:0]     s_tlast = '0;
   logic [NS-1:0]     s_tready;
   logic [NS*DW-1:0]  s_tdata = '0;
   logic [NS-1:0]     s_EF_ack;
   logic              m_frame_valid, m_tvalid, m_tlast;
   logic              m_tready = 1'b0;
   logic [1:0]        m_EFF;
   logic [DW-1:0]     m_tdata;
   logic              m_EF_ack = 1'b0;
   logic [IW-1:0]     grant_id;
   logic              busy;
`ifdef SDMF_ARB_STATS_EN
   logic [NS*16-1:0]  frame_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;
   int tlast_cnt = 0;

   sdmf_reduce_arbiter #(.NUM_SRC(NS), .DW(DW), .IDW(IW)) dut (
      .clk(clk), .reset(reset),
      .s_frame_valid(s_frame_valid), .s_EFF(s_EFF),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .s_tdata(s_tdata), .s_EF_ack(s_EF_ack),
      .m_frame_valid(m_frame_valid), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
      .m_tready(m_tready), .m_EFF(m_EFF), .m_tdata(m_tdata),
      .m_EF_ack(m_EF_ack), .grant_id(grant_id), .busy(busy)
`ifdef SDMF_ARB_STATS_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      s_frame_valid = '0;
      s_EFF         = '0;
      s_tvalid      = '0;
      s_tlast       = '0;
      s_tdata       = '0;
      m_EF_ack      = 1'b0;
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
   endtask

   // Source src is already granted; stream nb beats with m_tready held at 1.
   task automatic xfer(input int src, input int nb, input logic [DW-1:0] base);
      for (int b = 0; b < nb; b++) begin
         s_tdata[src*DW +: DW] = base + DW'(b);
         s_tlast[src]          = (b == nb - 1);
         #1;
         chk("xfer_tvalid", {31'd0, m_tvalid}, 32'd1);
         chk("xfer_tdata", {8'd0, m_tdata}, {8'd0, base + DW'(b)});
         chk("xfer_tready", {28'd0, s_tready}, 32'd1 << src);
         if (m_tlast && m_tready) tlast_cnt++;
         tick;
      end
      s_tlast[src] = 1'b0;
   endtask

   initial begin
      bit done;
      int beat;
      logic acc;
      logic [IW-1:0] rr_exp [6];
      rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // reset state
      tick;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant", {30'd0, grant_id}, 32'd0);
      chk("rst_fv", {31'd0, m_frame_valid}, 32'd0);
      chk("rst_tready", {28'd0, s_tready}, 32'd0);
      reset = 1'b0;

      // sources 0 and 2 request together: 0 first, one idle cycle, then 2
      s_frame_valid = 4'b0101;
      s_tvalid      = 4'b0101;
      m_tready      = 1'b1;
      #1;
      chk("idle_fv", {31'd0, m_frame_valid}, 32'd0);
      tick;
      chk("t1_grant0", {30'd0, grant_id}, 32'd0);
      chk("t1_fv", {31'd0, m_frame_valid}, 32'd1);
      xfer(0, 3, 24'h000100);
      s_frame_valid[0] = 1'b0;
      s_tvalid[0]      = 1'b0;
      #1;
      chk("t1_gap_busy", {31'd0, busy}, 32'd0);
      chk("t1_gap_fv", {31'd0, m_frame_valid}, 32'd0);
      tick;
      chk("t1_grant2", {30'd0, grant_id}, 32'd0 + 2);
      xfer(2, 3, 24'h000200);
      clear_inputs;
      #1;
      chk("t1_tlast_cnt", tlast_cnt, 32'd2);

      // four continuous 1-beat requesters rotate 0,1,2,3,0,1
      pulse_reset;
      s_frame_valid = 4'b1111;
      s_tvalid      = 4'b1111;
      s_tlast       = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("rr_grant", {30'd0, grant_id}, {30'd0, rr_exp[i]});
         chk("rr_tlast", {31'd0, m_tlast}, 32'd1);
         tick;
         chk("rr_gap", {31'd0, busy}, 32'd0);
      end
      clear_inputs;

      // empty frame from source 1, acknowledged after 5 cycles
      pulse_reset;
      s_frame_valid[1] = 1'b1;
      s_EFF            = 8'b0000_0100;
      tick;
      chk("ef_grant", {30'd0, grant_id}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("ef_eff", {30'd0, m_EFF}, 32'd1);
         chk("ef_tvalid", {31'd0, m_tvalid}, 32'd0);
         chk("ef_ack_early", {28'd0, s_EF_ack}, 32'd0);
         tick;
      end
      m_EF_ack = 1'b1;
      #1;
      chk("ef_ack", {28'd0, s_EF_ack}, 32'd2);
      chk("ef_tvalid_ack", {31'd0, m_tvalid}, 32'd0);
      tick;
      clear_inputs;
      #1;
      chk("ef_done_busy", {31'd0, busy}, 32'd0);
      chk("ef_done_eff", {30'd0, m_EFF}, 32'd0);
      chk("ef_ack_off", {28'd0, s_EF_ack}, 32'd0);

      // source 3, 4 beats, m_tready toggling; frame_valid dropped mid-frame
      s_frame_valid[3] = 1'b1;
      s_tvalid[3]      = 1'b1;
      tick;
      chk("bp_grant", {30'd0, grant_id}, 32'd3);
      s_frame_valid[3] = 1'b0;
      done = 1'b0;
      beat = 0;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         m_tready              = (cyc % 2 == 0);
         s_tdata[3*DW +: DW]   = 24'h000300 + DW'(beat);
         s_tlast[3]            = (beat == 3);
         #1;
         chk("bp_tready", {28'd0, s_tready}, {28'd0, m_tready, 3'b000});
         chk("bp_tdata", {8'd0, m_tdata}, 32'h300 + beat);
         acc = m_tready;
         tick;
         if (acc) begin
            if (beat == 3) done = 1'b1;
            else beat++;
         end
         chk("bp_busy", {31'd0, busy}, {31'd0, !done});
      end
      chk("bp_done", {31'd0, done}, 32'd1);
      chk("bp_beats", beat, 32'd3);
      clear_inputs;
      m_tready = 1'b1;

      // reset during beat 2 of a 5-beat frame from source 1
      s_frame_valid[1] = 1'b1;
      s_tvalid[1]      = 1'b1;
      tick;
      chk("mr_grant", {30'd0, grant_id}, 32'd1);
      s_tdata[1*DW +: DW] = 24'h000400;
      tick;
      s_tdata[1*DW +: DW] = 24'h000401;
      s_tlast[1]          = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      chk("mr_fv", {31'd0, m_frame_valid}, 32'd0);
      chk("mr_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("mr_tlast", {31'd0, m_tlast}, 32'd0);
      chk("mr_tdata", {8'd0, m_tdata}, 32'd0);
      chk("mr_eff", {30'd0, m_EFF}, 32'd0);
      chk("mr_tready", {28'd0, s_tready}, 32'd0);
      chk("mr_efack", {28'd0, s_EF_ack}, 32'd0);
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_gid", {30'd0, grant_id}, 32'd0);
      clear_inputs;
      s_frame_valid = 4'b1011;
      tick;
      reset = 1'b0;
      tick;
      chk("mr_next_grant", {30'd0, grant_id}, 32'd0);
      chk("mr_next_fv", {31'd0, m_frame_valid}, 32'd1);
      clear_inputs;
      pulse_reset;

`ifdef SDMF_ARB_STATS_EN
      // source 2 completes three 1-beat frames
      s_frame_valid[2] = 1'b1;
      s_tvalid[2]      = 1'b1;
      s_tlast[2]       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         tick;
      end
      clear_inputs;
      for (int i = 0; i < NS; i++)
         chk("stats_cnt", {16'd0, frame_cnt[i*16 +: 16]}, (i == 2) ? 32'd3 : 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule

// File: doc/sdmf_reduce_arbiter.md
SDMF_REDUCE_ARBITER -- requirements
Module: sdmf_reduce_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4: number of SDMF triple-stream requesters, 2..16.
REQ-002 The block SHALL have parameter DW, default 24: triple width, equal to the reduce engine's I_DATA_WIDTH.
REQ-003 The block SHALL have parameter IDW, default 2: grant index width, at least clog2(NUM_SRC).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port s_frame_valid, input, NUM_SRC bits: per-source frame request, valid for the whole frame.
REQ-007 The block SHALL have port s_EFF, input, 2*NUM_SRC bits: per-source empty-frame flag; nonzero means empty frame.
REQ-008 The block SHALL have ports s_tvalid, s_tlast (inputs, NUM_SRC bits) and s_tready (output, NUM_SRC bits): per-source beat handshake.
REQ-009 The block SHALL have port s_tdata, input, NUM_SRC*DW bits: source i occupies bits [i*DW +: DW].
REQ-010 The block SHALL have port s_EF_ack, output, NUM_SRC bits: per-source empty-frame acknowledge.
REQ-011 The block SHALL have ports m_frame_valid, m_tvalid, m_tlast (outputs, 1 bit) and m_tready (input, 1 bit): handshake toward the reduce engine.
REQ-012 The block SHALL have port m_EFF, output, 2 bits: EFF of the granted frame.
REQ-013 The block SHALL have port m_tdata, output, DW bits: data of the granted source.
REQ-014 The block SHALL have port m_EF_ack, input, 1 bit: empty-frame acknowledge from the reduce engine.
REQ-015 The block SHALL have ports grant_id (output, IDW bits) and busy (output, 1 bit): the current owner, and busy=1 whenever state is not IDLE.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, XFER and EMPTY.
REQ-017 IDLE: when any s_frame_valid bit is 1, the block SHALL register grant_id as the first requesting source after last_grant, in round-robin order with wrap from NUM_SRC-1 to 0.
REQ-018 On that same edge, the FSM SHALL go to EMPTY if the winner's s_EFF is nonzero, else to XFER.
REQ-019 m_frame_valid SHALL be 1 exactly in XFER and EMPTY, so it rises one cycle after the request is seen in IDLE.
REQ-020 XFER: m_tvalid, m_tlast and m_tdata SHALL be combinational copies of the granted source's signals.
REQ-021 XFER: s_tready[grant_id] SHALL equal m_tready; the block SHALL add zero latency and no buffering.
REQ-022 Ungranted s_tready bits SHALL be 0 in every state.
REQ-023 m_tvalid and m_tlast SHALL be 0 outside XFER.
REQ-024 XFER SHALL exit to IDLE on m_tvalid & m_tready & m_tlast, and SHALL set last_grant to grant_id on that edge.
REQ-025 EMPTY: m_EFF SHALL equal the granted s_EFF; elsewhere m_EFF SHALL be 2'b00.
REQ-026 EMPTY: s_EF_ack[grant_id] SHALL equal m_EF_ack; all other s_EF_ack bits SHALL be 0.
REQ-027 EMPTY SHALL exit to IDLE on m_EF_ack = 1, and SHALL update last_grant.
REQ-028 Once granted, the grant SHALL be held until frame completion; deassertion of s_frame_valid mid-frame and requests from other sources SHALL be ignored.
REQ-029 At least one IDLE cycle SHALL separate consecutive frames.
REQ-030 A single requester SHALL be re-granted after each frame.
REQ-031 A last beat accepted while m_tready = 0 SHALL NOT end the frame; only a completed handshake ends it.

Reset
REQ-032 On reset the block SHALL force state = IDLE, grant_id = 0, last_grant = NUM_SRC-1 (source 0 has first priority) and busy = 0.
REQ-033 On reset all m_* outputs and all s_tready and s_EF_ack bits SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately, with no m_tlast generated.
REQ-035 After reset is released, arbitration SHALL restart from IDLE on the next edge.

Configuration
REQ-036 With SDMF_ARB_STATS_EN defined, the block SHALL add output frame_cnt, NUM_SRC*16 bits: a per-source count of completed frames (data or empty).
REQ-037 Each frame_cnt counter SHALL increment on its source's exit edge, wrap from 16'hFFFF to 0, and clear on reset.
REQ-038 Without SDMF_ARB_STATS_EN, the frame_cnt port and its counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-039 Sources 0 and 2 request together from reset, 3 beats each, m_tready = 1 -> source 0 is served first (grant_id = 0), then 1 IDLE cycle, then source 2; m_tlast is seen exactly twice.
REQ-040 All four sources request continuously with 1-beat frames -> grant_id sequence is 0,1,2,3,0,1, with no source starved.
REQ-041 Source 1 sends an empty frame (s_EFF = 2'b01) and m_EF_ack is pulsed after 5 cycles -> m_EFF = 2'b01 for 5 cycles, s_EF_ack[1] is pulsed for 1 cycle, and m_tvalid = 0 throughout.
REQ-042 Source 3 sends 4 beats while m_tready toggles 1,0,1,0 -> s_tready[3] mirrors m_tready, all 4 beats pass in order, and the frame ends only on the handshaked tlast.
REQ-043 Reset is asserted during beat 2 of a 5-beat frame -> all outputs are 0 in the same cycle, and the next grant goes to source 0.
REQ-044 With SDMF_ARB_STATS_EN defined, source 2 completes 3 frames -> frame_cnt[2] = 3 and all other counters = 0.
